// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit: operand forwarding and load-use stall control between ID and EX.
// Resolves each source operand from EX, MEM, WB or the register file, stalls ID
// for LOAD_USE_CYCLES cycles after a load-use hazard, registers the resolved
// operands into EX and keeps saturating stall/forward performance counters.
module fwd_stall_unit #(
   parameter int XLEN            = 32,
   parameter int REG_AW          = 5,
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_ra_index_i,
   input  logic [REG_AW-1:0] id_rb_index_i,
   input  logic              id_uses_ra_i,
   input  logic              id_uses_rb_i,
   input  logic [XLEN-1:0]   id_ra_value_i,
   input  logic [XLEN-1:0]   id_rb_value_i,
   input  logic              ex_valid_i,
   input  logic              ex_is_load_i,
   input  logic [REG_AW-1:0] ex_rd_index_i,
   input  logic [XLEN-1:0]   ex_result_i,
   input  logic              mem_valid_i,
   input  logic              mem_access_i,
   input  logic [REG_AW-1:0] mem_rd_index_i,
   input  logic [XLEN-1:0]   mem_alu_result_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              wb_valid_i,
   input  logic [REG_AW-1:0] wb_rd_index_i,
   input  logic [XLEN-1:0]   wb_result_i,
   input  logic              clr_counters_i,
   output logic              stall_o,
   output logic              exe_valid_o,
   output logic [XLEN-1:0]   exe_ra_o,
   output logic [XLEN-1:0]   exe_rb_o,
   output logic [1:0]        fwd_sel_a_o,
   output logic [1:0]        fwd_sel_b_o,
   output logic [CNT_W-1:0]  stall_count_o,
   output logic [CNT_W-1:0]  fwd_count_o
);

   localparam logic       ST_RUN    = 1'b0;
   localparam logic       ST_STALL  = 1'b1;
   localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_EX  = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;
   localparam logic [1:0] SEL_WB  = 2'd3;

   // A producer feeds an operand only if it writes a non-zero register the operand reads.
   function automatic logic prod_match(input logic              p_valid,
                                       input logic [REG_AW-1:0] p_rd,
                                       input logic [REG_AW-1:0] src_idx,
                                       input logic              src_used);
      return p_valid && (p_rd != {REG_AW{1'b0}}) && (p_rd == src_idx) && src_used;
   endfunction

   // Counter increment that sticks at all ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1'b1);
   endfunction

   logic              state_r, state_n_s;
   logic [2:0]        cnt_r, cnt_n_s;
   logic              hazard_s, stall_s, fwd_event_s;
   logic              ex_a_s, ex_b_s, mem_a_s, mem_b_s, wb_a_s, wb_b_s;
   logic [XLEN-1:0]   mem_value_s, op_a_s, op_b_s;
   logic [1:0]        sel_a_s, sel_b_s;
   logic              exe_valid_r;
   logic [XLEN-1:0]   exe_ra_r, exe_rb_r;
   logic [1:0]        sel_a_r, sel_b_r;
   logic [CNT_W-1:0]  stall_cnt_r, fwd_cnt_r;

   assign ex_a_s  = prod_match(ex_valid_i,  ex_rd_index_i,  id_ra_index_i, id_uses_ra_i);
   assign ex_b_s  = prod_match(ex_valid_i,  ex_rd_index_i,  id_rb_index_i, id_uses_rb_i);
   assign mem_a_s = prod_match(mem_valid_i, mem_rd_index_i, id_ra_index_i, id_uses_ra_i);
   assign mem_b_s = prod_match(mem_valid_i, mem_rd_index_i, id_rb_index_i, id_uses_rb_i);
   assign wb_a_s  = prod_match(wb_valid_i,  wb_rd_index_i,  id_ra_index_i, id_uses_ra_i);
   assign wb_b_s  = prod_match(wb_valid_i,  wb_rd_index_i,  id_rb_index_i, id_uses_rb_i);

   assign hazard_s = id_valid_i && ex_is_load_i && (ex_a_s || ex_b_s);

   // MEM stage value: load data for loads, ALU result otherwise.
   always_comb begin
      mem_value_s = mem_alu_result_i;
      if (mem_access_i) begin
         mem_value_s = mem_rdata_i;
      end else begin
         mem_value_s = mem_alu_result_i;
      end
   end

   // Source select per operand: EX > MEM > WB > regfile; EX is barred while a load-use hazard stands.
   always_comb begin
      sel_a_s = SEL_RF;
      sel_b_s = SEL_RF;
      if (!id_valid_i) begin
         sel_a_s = SEL_RF;
         sel_b_s = SEL_RF;
      end else begin
         if (ex_a_s && !hazard_s) sel_a_s = SEL_EX;
         else if (mem_a_s)        sel_a_s = SEL_MEM;
         else if (wb_a_s)         sel_a_s = SEL_WB;
         else                     sel_a_s = SEL_RF;
         if (ex_b_s && !hazard_s) sel_b_s = SEL_EX;
         else if (mem_b_s)        sel_b_s = SEL_MEM;
         else if (wb_b_s)         sel_b_s = SEL_WB;
         else                     sel_b_s = SEL_RF;
      end
   end

   // Operand muxes driven by the resolved selects.
   always_comb begin
      op_a_s = id_ra_value_i;
      op_b_s = id_rb_value_i;
      case (sel_a_s)
         SEL_EX:  op_a_s = ex_result_i;
         SEL_MEM: op_a_s = mem_value_s;
         SEL_WB:  op_a_s = wb_result_i;
         default: op_a_s = id_ra_value_i;
      endcase
      case (sel_b_s)
         SEL_EX:  op_b_s = ex_result_i;
         SEL_MEM: op_b_s = mem_value_s;
         SEL_WB:  op_b_s = wb_result_i;
         default: op_b_s = id_rb_value_i;
      endcase
   end

   // Stall request: the whole STALL state, or the hazard cycle itself; reset forces it low.
   always_comb begin
      stall_s = 1'b0;
      if (!reset_ni) begin
         stall_s = 1'b0;
      end else if (state_r == ST_STALL) begin
         stall_s = 1'b1;
      end else begin
         stall_s = hazard_s;
      end
   end

   assign stall_o     = stall_s;
   assign fwd_event_s = id_valid_i && !stall_s && ((sel_a_s != SEL_RF) || (sel_b_s != SEL_RF));

   // Next-state logic: the hazard cycle counts as the first stall cycle, STALL covers the rest.
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      case (state_r)
         ST_RUN: begin
            if (hazard_s && (LOAD_USE_CYCLES > 1)) begin
               state_n_s = ST_STALL;
               cnt_n_s   = LU_RELOAD;
            end else begin
               state_n_s = ST_RUN;
               cnt_n_s   = 3'd0;
            end
         end
         ST_STALL: begin
            if (cnt_r <= 3'd1) begin
               state_n_s = ST_RUN;
               cnt_n_s   = 3'd0;
            end else begin
               state_n_s = ST_STALL;
               cnt_n_s   = cnt_r - 3'd1;
            end
         end
         default: begin
            state_n_s = ST_RUN;
            cnt_n_s   = 3'd0;
         end
      endcase
   end

   // Stall FSM state and countdown registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_r <= ST_RUN;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_n_s;
         cnt_r   <= cnt_n_s;
      end
   end

   // ID/EX register: bubble and hold while stalled, otherwise capture resolved operands.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         exe_valid_r <= 1'b0;
         exe_ra_r    <= {XLEN{1'b0}};
         exe_rb_r    <= {XLEN{1'b0}};
         sel_a_r     <= SEL_RF;
         sel_b_r     <= SEL_RF;
      end else if (stall_s) begin
         exe_valid_r <= 1'b0;
      end else begin
         exe_valid_r <= id_valid_i;
         exe_ra_r    <= op_a_s;
         exe_rb_r    <= op_b_s;
         sel_a_r     <= sel_a_s;
         sel_b_r     <= sel_b_s;
      end
   end

   // Saturating performance counters; a clear beats a same-cycle increment.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         fwd_cnt_r   <= {CNT_W{1'b0}};
      end else if (clr_counters_i) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         fwd_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         if (stall_s)     stall_cnt_r <= sat_inc(stall_cnt_r);
         if (fwd_event_s) fwd_cnt_r   <= sat_inc(fwd_cnt_r);
      end
   end

   assign exe_valid_o   = exe_valid_r;
   assign exe_ra_o      = exe_ra_r;
   assign exe_rb_o      = exe_rb_r;
   assign fwd_sel_a_o   = sel_a_r;
   assign fwd_sel_b_o   = sel_b_r;
   assign stall_count_o = stall_cnt_r;
   assign fwd_count_o   = fwd_cnt_r;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Testbench for fwd_stall_unit: three instances with different stall lengths and
// counter widths share one stimulus stream and are compared every cycle against
// a behavioural model, plus directed checks from the feature list.
module tb_fwd_stall_unit;

   localparam int NI = 3;
   localparam int LU [NI] = '{1, 3, 2};
   localparam int CW [NI] = '{16, 16, 2};

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic        id_valid, id_uses_ra, id_uses_rb;
   logic [4:0]  id_ra_idx, id_rb_idx, ex_rd, mem_rd, wb_rd;
   logic [31:0] id_ra_val, id_rb_val, ex_res, mem_alu, mem_rdata, wb_res;
   logic        ex_valid, ex_is_load, mem_valid, mem_access, wb_valid, clr;

   logic        stall_w [NI];
   logic        exv_w   [NI];
   logic [31:0] ra_w    [NI];
   logic [31:0] rb_w    [NI];
   logic [1:0]  sa_w    [NI];
   logic [1:0]  sb_w    [NI];
   logic [15:0] sc0, sc1, fc0, fc1;
   logic [1:0]  sc2, fc2;

   int checks = 0;
   int errors = 0;

   // model state
   int          stall_left [NI];
   bit          stall_now  [NI];
   logic        m_valid    [NI];
   logic [31:0] m_ra [NI], m_rb [NI];
   logic [1:0]  m_sa [NI], m_sb [NI];
   longint      m_sc [NI], m_fc [NI];

   always #5 clk = ~clk;

   fwd_stall_unit #(.LOAD_USE_CYCLES(1), .CNT_W(16)) u_dut0 (
      .clk_i(clk), .reset_ni(reset_ni), .id_valid_i(id_valid),
      .id_ra_index_i(id_ra_idx), .id_rb_index_i(id_rb_idx),
      .id_uses_ra_i(id_uses_ra), .id_uses_rb_i(id_uses_rb),
      .id_ra_value_i(id_ra_val), .id_rb_value_i(id_rb_val),
      .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_index_i(ex_rd), .ex_result_i(ex_res),
      .mem_valid_i(mem_valid), .mem_access_i(mem_access), .mem_rd_index_i(mem_rd),
      .mem_alu_result_i(mem_alu), .mem_rdata_i(mem_rdata),
      .wb_valid_i(wb_valid), .wb_rd_index_i(wb_rd), .wb_result_i(wb_res),
      .clr_counters_i(clr), .stall_o(stall_w[0]), .exe_valid_o(exv_w[0]),
      .exe_ra_o(ra_w[0]), .exe_rb_o(rb_w[0]), .fwd_sel_a_o(sa_w[0]), .fwd_sel_b_o(sb_w[0]),
      .stall_count_o(sc0), .fwd_count_o(fc0));

   fwd_stall_unit #(.LOAD_USE_CYCLES(3), .CNT_W(16)) u_dut1 (
      .clk_i(clk), .reset_ni(reset_ni), .id_valid_i(id_valid),
      .id_ra_index_i(id_ra_idx), .id_rb_index_i(id_rb_idx),
      .id_uses_ra_i(id_uses_ra), .id_uses_rb_i(id_uses_rb),
      .id_ra_value_i(id_ra_val), .id_rb_value_i(id_rb_val),
      .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_index_i(ex_rd), .ex_result_i(ex_res),
      .mem_valid_i(mem_valid), .mem_access_i(mem_access), .mem_rd_index_i(mem_rd),
      .mem_alu_result_i(mem_alu), .mem_rdata_i(mem_rdata),
      .wb_valid_i(wb_valid), .wb_rd_index_i(wb_rd), .wb_result_i(wb_res),
      .clr_counters_i(clr), .stall_o(stall_w[1]), .exe_valid_o(exv_w[1]),
      .exe_ra_o(ra_w[1]), .exe_rb_o(rb_w[1]), .fwd_sel_a_o(sa_w[1]), .fwd_sel_b_o(sb_w[1]),
      .stall_count_o(sc1), .fwd_count_o(fc1));

   fwd_stall_unit #(.LOAD_USE_CYCLES(2), .CNT_W(2)) u_dut2 (
      .clk_i(clk), .reset_ni(reset_ni), .id_valid_i(id_valid),
      .id_ra_index_i(id_ra_idx), .id_rb_index_i(id_rb_idx),
      .id_uses_ra_i(id_uses_ra), .id_uses_rb_i(id_uses_rb),
      .id_ra_value_i(id_ra_val), .id_rb_value_i(id_rb_val),
      .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_index_i(ex_rd), .ex_result_i(ex_res),
      .mem_valid_i(mem_valid), .mem_access_i(mem_access), .mem_rd_index_i(mem_rd),
      .mem_alu_result_i(mem_alu), .mem_rdata_i(mem_rdata),
      .wb_valid_i(wb_valid), .wb_rd_index_i(wb_rd), .wb_result_i(wb_res),
      .clr_counters_i(clr), .stall_o(stall_w[2]), .exe_valid_o(exv_w[2]),
      .exe_ra_o(ra_w[2]), .exe_rb_o(rb_w[2]), .fwd_sel_a_o(sa_w[2]), .fwd_sel_b_o(sb_w[2]),
      .stall_count_o(sc2), .fwd_count_o(fc2));

   function automatic logic [63:0] obs_sc(input int k);
      case (k)
         0:       return {48'd0, sc0};
         1:       return {48'd0, sc1};
         default: return {62'd0, sc2};
      endcase
   endfunction

   function automatic logic [63:0] obs_fc(input int k);
      case (k)
         0:       return {48'd0, fc0};
         1:       return {48'd0, fc1};
         default: return {62'd0, fc2};
      endcase
   endfunction

   task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[dut%0d]: observed 0x%0h expected 0x%0h", tag, k, obs, exp);
      end
   endtask

   function automatic bit hits(input bit v, input logic [4:0] rd, input logic [4:0] idx, input bit used);
      return v && (rd != 5'd0) && (rd == idx) && used;
   endfunction

   // Walk producers in priority order and take the first that writes the register read.
   task automatic resolve(input logic [4:0] idx, input bit used, input logic [31:0] rf_val,
                          input bit hz, output logic [1:0] sel, output logic [31:0] val);
      bit          pv [3];
      logic [4:0]  prd [3];
      logic [31:0] pval [3];
      pv[0] = ex_valid && !hz;  prd[0] = ex_rd;  pval[0] = ex_res;
      pv[1] = mem_valid;        prd[1] = mem_rd; pval[1] = mem_access ? mem_rdata : mem_alu;
      pv[2] = wb_valid;         prd[2] = wb_rd;  pval[2] = wb_res;
      sel = 2'd0;
      val = rf_val;
      if (id_valid) begin
         for (int i = 0; i < 3; i++) begin
            if (hits(pv[i], prd[i], idx, used)) begin
               sel = 2'(i + 1);
               val = pval[i];
               break;
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         stall_left[k] = 0; m_valid[k] = 1'b0; m_ra[k] = 32'd0; m_rb[k] = 32'd0;
         m_sa[k] = 2'd0; m_sb[k] = 2'd0; m_sc[k] = 0; m_fc[k] = 0;
      end
   endtask

   task automatic check_regs();
      for (int k = 0; k < NI; k++) begin
         chk("exe_valid", k, {63'd0, exv_w[k]}, {63'd0, m_valid[k]});
         chk("exe_ra", k, {32'd0, ra_w[k]}, {32'd0, m_ra[k]});
         chk("exe_rb", k, {32'd0, rb_w[k]}, {32'd0, m_rb[k]});
         chk("sel_a", k, {62'd0, sa_w[k]}, {62'd0, m_sa[k]});
         chk("sel_b", k, {62'd0, sb_w[k]}, {62'd0, m_sb[k]});
         chk("stall_count", k, obs_sc(k), 64'(m_sc[k]));
         chk("fwd_count", k, obs_fc(k), 64'(m_fc[k]));
      end
   endtask

   // One clock: check stall_o mid-cycle, let the edge happen, update model, check registers.
   task automatic cycle();
      bit          hz;
      logic [1:0]  sa, sb;
      logic [31:0] va, vb;
      longint      mx;
      hz = id_valid && ex_is_load &&
           (hits(ex_valid, ex_rd, id_ra_idx, id_uses_ra) || hits(ex_valid, ex_rd, id_rb_idx, id_uses_rb));
      resolve(id_ra_idx, id_uses_ra, id_ra_val, hz, sa, va);
      resolve(id_rb_idx, id_uses_rb, id_rb_val, hz, sb, vb);
      for (int k = 0; k < NI; k++) stall_now[k] = (stall_left[k] > 0) || hz;
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk("stall_o", k, {63'd0, stall_w[k]}, {63'd0, stall_now[k]});
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         mx = (64'd1 << CW[k]) - 1;
         if (clr) begin
            m_sc[k] = 0; m_fc[k] = 0;
         end else begin
            if (stall_now[k] && m_sc[k] < mx) m_sc[k]++;
            if (!stall_now[k] && id_valid && (sa != 2'd0 || sb != 2'd0) && m_fc[k] < mx) m_fc[k]++;
         end
         if (stall_now[k]) begin
            m_valid[k] = 1'b0;
         end else begin
            m_valid[k] = id_valid; m_ra[k] = va; m_rb[k] = vb; m_sa[k] = sa; m_sb[k] = sb;
         end
         if (stall_left[k] > 0) stall_left[k]--;
         else if (hz) stall_left[k] = LU[k] - 1;
      end
      #1;
      check_regs();
   endtask

   task automatic idle();
      id_valid = 1'b0; id_uses_ra = 1'b0; id_uses_rb = 1'b0;
      id_ra_idx = 5'd0; id_rb_idx = 5'd0; id_ra_val = 32'd0; id_rb_val = 32'd0;
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_res = 32'd0;
      mem_valid = 1'b0; mem_access = 1'b0; mem_rd = 5'd0; mem_alu = 32'd0; mem_rdata = 32'd0;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_res = 32'd0; clr = 1'b0;
   endtask

   task automatic check_all_zero();
      for (int k = 0; k < NI; k++) begin
         chk("rst_stall", k, {63'd0, stall_w[k]}, 64'd0);
         chk("rst_valid", k, {63'd0, exv_w[k]}, 64'd0);
         chk("rst_ra", k, {32'd0, ra_w[k]}, 64'd0);
         chk("rst_rb", k, {32'd0, rb_w[k]}, 64'd0);
         chk("rst_sel_a", k, {62'd0, sa_w[k]}, 64'd0);
         chk("rst_sel_b", k, {62'd0, sb_w[k]}, 64'd0);
         chk("rst_scnt", k, obs_sc(k), 64'd0);
         chk("rst_fcnt", k, obs_fc(k), 64'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero();
      reset_ni = 1'b1;

      // EX beats MEM for the same register
      idle();
      ex_valid = 1'b1; ex_rd = 5'd5; ex_res = 32'h11;
      mem_valid = 1'b1; mem_rd = 5'd5; mem_alu = 32'h22;
      id_valid = 1'b1; id_ra_idx = 5'd5; id_uses_ra = 1'b1; id_ra_val = 32'hAAAA;
      cycle();
      chk("ex_fwd_ra", 0, {32'd0, ra_w[0]}, 64'h11);
      chk("ex_fwd_sel", 0, {62'd0, sa_w[0]}, 64'd1);
      chk("ex_fwd_cnt", 0, {48'd0, fc0}, 64'd1);

      // MEM load data on rb, WB on ra
      idle();
      mem_valid = 1'b1; mem_access = 1'b1; mem_rd = 5'd7; mem_rdata = 32'hDEAD; mem_alu = 32'h1;
      wb_valid = 1'b1; wb_rd = 5'd3; wb_res = 32'h33;
      id_valid = 1'b1; id_ra_idx = 5'd3; id_rb_idx = 5'd7; id_uses_ra = 1'b1; id_uses_rb = 1'b1;
      cycle();
      chk("mem_fwd_rb", 0, {32'd0, rb_w[0]}, 64'hDEAD);
      chk("mem_fwd_sel", 0, {62'd0, sb_w[0]}, 64'd2);
      chk("wb_fwd_ra", 0, {32'd0, ra_w[0]}, 64'h33);
      chk("wb_fwd_sel", 0, {62'd0, sa_w[0]}, 64'd3);

      // load-use: hazard cycle, then the load moves on to MEM
      idle();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_res = 32'h77;
      id_valid = 1'b1; id_ra_idx = 5'd9; id_uses_ra = 1'b1; id_ra_val = 32'h99;
      cycle();
      chk("lu_bubble", 0, {63'd0, exv_w[0]}, 64'd0);
      ex_valid = 1'b0; ex_is_load = 1'b0;
      mem_valid = 1'b1; mem_access = 1'b1; mem_rd = 5'd9; mem_rdata = 32'hBEEF;
      cycle();
      chk("lu_mem_ra", 0, {32'd0, ra_w[0]}, 64'hBEEF);
      chk("lu_mem_sel", 0, {62'd0, sa_w[0]}, 64'd2);
      chk("lu3_still", 1, {63'd0, stall_w[1]}, 64'd1);
      cycle();
      cycle();
      chk("lu3_released", 1, {63'd0, stall_w[1]}, 64'd0);
      chk("lu_scnt1", 0, {48'd0, sc0}, 64'd1);
      chk("lu_scnt3", 1, {48'd0, sc1}, 64'd3);
      chk("lu_scnt2", 2, {62'd0, sc2}, 64'd2);
      chk("lu3_ra", 1, {32'd0, ra_w[1]}, 64'hBEEF);

      // reset during the second stall cycle of the 3-cycle instance
      idle();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
      id_valid = 1'b1; id_ra_idx = 5'd9; id_uses_ra = 1'b1;
      cycle();
      ex_valid = 1'b0; ex_is_load = 1'b0;
      #2;
      reset_ni = 1'b0;
      #1;
      model_reset();
      check_all_zero();
      @(posedge clk);
      #1;
      reset_ni = 1'b1;
      cycle();
      chk("post_rst_run", 1, {63'd0, stall_w[1]}, 64'd0);

      // x0 is never forwarded
      idle();
      ex_valid = 1'b1; ex_rd = 5'd0; ex_res = 32'hFF;
      id_valid = 1'b1; id_ra_idx = 5'd0; id_uses_ra = 1'b1; id_ra_val = 32'h5A;
      cycle();
      chk("x0_sel", 0, {62'd0, sa_w[0]}, 64'd0);
      chk("x0_ra", 0, {32'd0, ra_w[0]}, 64'h5A);

      // unused rb matching an EX load must not stall
      idle();
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12;
      id_valid = 1'b1; id_rb_idx = 5'd12; id_uses_rb = 1'b0; id_ra_idx = 5'd4; id_uses_ra = 1'b1;
      cycle();
      chk("unused_valid", 0, {63'd0, exv_w[0]}, 64'd1);
      chk("unused_sel_b", 0, {62'd0, sb_w[0]}, 64'd0);

      // saturation of the narrow forward counter, then clear beats increment
      idle();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      wb_valid = 1'b1; wb_rd = 5'd6; wb_res = 32'h66;
      id_valid = 1'b1; id_ra_idx = 5'd6; id_uses_ra = 1'b1;
      repeat (5) cycle();
      chk("fwd_sat", 2, {62'd0, fc2}, 64'd3);
      chk("fwd_wide", 0, {48'd0, fc0}, 64'd5);
      clr = 1'b1;
      cycle();
      chk("fwd_clr", 2, {62'd0, fc2}, 64'd0);
      chk("fwd_clr_wide", 0, {48'd0, fc0}, 64'd0);
      clr = 1'b0;

      // randomized traffic over a small register window to provoke matches
      for (int n = 0; n < 300; n++) begin
         id_valid   = 1'($urandom_range(0, 3) != 0);
         id_uses_ra = 1'($urandom_range(0, 1));
         id_uses_rb = 1'($urandom_range(0, 1));
         id_ra_idx  = 5'($urandom_range(0, 3));
         id_rb_idx  = 5'($urandom_range(0, 3));
         id_ra_val  = $urandom; id_rb_val = $urandom;
         ex_valid   = 1'($urandom_range(0, 1));
         ex_is_load = 1'($urandom_range(0, 3) == 0);
         ex_rd      = 5'($urandom_range(0, 3));
         ex_res     = $urandom;
         mem_valid  = 1'($urandom_range(0, 1));
         mem_access = 1'($urandom_range(0, 1));
         mem_rd     = 5'($urandom_range(0, 3));
         mem_alu    = $urandom; mem_rdata = $urandom;
         wb_valid   = 1'($urandom_range(0, 1));
         wb_rd      = 5'($urandom_range(0, 3));
         wb_res     = $urandom;
         clr        = 1'($urandom_range(0, 15) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_stall_unit.md
# fwd_stall_unit

Parametrised forwarding and load-use stall unit for the RISC-V pipeline, sitting between the ID stage and the EX stage. It resolves operand sources from three in-flight producers (EX, MEM and WB) plus the register file. When a dependent instruction directly follows a load, it stalls ID for a configurable number of cycles. It registers the selected operands into EX and keeps saturating performance counters for stalls and forwards.

## Interface
Parameters:
- XLEN, 32, operand and result width
- REG_AW, 5, register index width; index 0 is hardwired zero
- LOAD_USE_CYCLES, 1, stall cycles per load-use hazard (legal range 1 to 7)
- CNT_W, 16, performance counter width

Ports:
- clk_i  in  1  clock, all flops on the rising edge
- reset_ni  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID holds a valid instruction
- id_ra_index_i, id_rb_index_i  in  REG_AW  source register indices
- id_uses_ra_i, id_uses_rb_i  in  1  the instruction actually reads that operand
- id_ra_value_i, id_rb_value_i  in  XLEN  register-file read data
- ex_valid_i, ex_is_load_i  in  1  EX instruction valid / is a load
- ex_rd_index_i  in  REG_AW;  ex_result_i  in  XLEN  EX destination and ALU result
- mem_valid_i, mem_access_i  in  1  MEM instruction valid / is a load
- mem_rd_index_i  in  REG_AW;  mem_alu_result_i, mem_rdata_i  in  XLEN
- wb_valid_i  in  1;  wb_rd_index_i  in  REG_AW;  wb_result_i  in  XLEN
- clr_counters_i  in  1  synchronous clear of both counters
- stall_o  out  1  freeze PC and IF/ID (combinational)
- exe_valid_o  out  1  registered valid into EX; 0 marks a bubble
- exe_ra_o, exe_rb_o  out  XLEN  registered resolved operands
- fwd_sel_a_o, fwd_sel_b_o  out  2  registered source: 0 regfile, 1 EX, 2 MEM, 3 WB
- stall_count_o, fwd_count_o  out  CNT_W  saturating counters

## Operation
- **Match rule.** A producer P matches operand X when all of these hold: P_valid, P_rd != 0, P_rd == id_X_index, and id_uses_X.
- **Source priority.** EX, then MEM, then WB, then the register file.
- **MEM value.** The MEM stage supplies mem_rdata_i when mem_access_i=1, otherwise mem_alu_result_i.
- **Load-use hazard.** Raised when id_valid_i and ex_is_load_i are both set and EX matches operand a or operand b. EX is never selected as a forwarding source while the hazard is present.
- **FSM states.** RUN and STALL, with a 3-bit counter.
  - In RUN with a hazard: stall_o=1. If LOAD_USE_CYCLES>1, go to STALL with counter=LOAD_USE_CYCLES-1.
  - In STALL: stall_o=1 and the counter decrements each cycle. When the counter reaches 1 and decrements, return to RUN.
- **EX register update, no stall.** exe_valid_o<=id_valid_i; operands and selects take the resolved values.
- **EX register update, stall.** exe_valid_o<=0; operands and selects hold.
- **Invalid ID.** When id_valid_i=0, selects are 0 and operands pass the register-file values.
- **stall_count_o.** Increments on every cycle with stall_o=1.
- **fwd_count_o.** Increments by one on any non-stalled valid cycle where either select is non-zero.
- **Counter rules.**
  - Both counters saturate at all ones.
  - clr_counters_i clears both counters and wins over an increment in the same cycle.

## Timing
- **Reset.** Asserting reset_ni=0 at any time, including mid-stall, immediately forces:
  - state RUN, counter 0, stall_o 0;
  - exe_valid_o 0, exe_ra_o 0, exe_rb_o 0;
  - fwd_sel_a_o 0, fwd_sel_b_o 0;
  - both performance counters 0.
- **Latency.**
  - stall_o is valid in the same cycle as its inputs.
  - Operands and selects appear on EX outputs 1 cycle after the ID inputs are sampled.
- **Load-use sequence, LOAD_USE_CYCLES=1.**
  - Cycle t: hazard detected, stall_o=1.
  - Edge t+1: bubble written into EX.
  - Cycle t+1: the load is in MEM, stall_o=0, and the operand resolves from mem_rdata_i.
- **Load-use sequence, LOAD_USE_CYCLES=N.** stall_o stays high for exactly N consecutive cycles.
- **Simultaneous matches.** When EX, MEM and WB all match, EX wins unless EX is a load, which stalls.
- **Register 0.** A producer writing index 0 is never forwarded.
- **Operand independence.** Operand a and operand b resolve independently; they may use different sources in the same cycle.

## Test plan
- **EX forward.** EX writes x5=0x11, MEM writes x5=0x22, ID reads ra=x5 → next cycle exe_ra_o=0x11, fwd_sel_a_o=1, fwd_count_o increments by 1.
- **MEM load and WB forward.** MEM load to x7 with mem_rdata_i=0xDEAD, ID rb=x7, WB writes x3=0x33 for ra=x3 → exe_rb_o=0xDEAD (sel 2) and exe_ra_o=0x33 (sel 3).
- **Load-use, single cycle.** EX load to x9 and ID reads x9 with LOAD_USE_CYCLES=1 → stall_o=1 for one cycle, exe_valid_o=0 one cycle later, then exe_ra_o=mem_rdata_i with sel 2.
- **Load-use, three cycles.** LOAD_USE_CYCLES=3 → stall_o high for exactly 3 cycles and stall_count_o=3. Reset is then asserted during the 2nd stall cycle → all outputs return to zero immediately and the FSM is in RUN.
- **Zero register and unused operands.** EX writes x0=0xFF and ID reads x0 → sel 0 and the register-file value is used. With id_uses_rb_i=0 and rb matching an EX load → no stall.
- **Counter saturation and clear.** With CNT_W=2, drive 5 forwards → fwd_count_o=3. Assert clr_counters_i together with another forward → fwd_count_o=0.
